// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with a 2-flop input synchroniser and false-start rejection.
// It reports parity and framing errors together with a single-cycle data_valid strobe.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_acc_q, par_acc_d;
  logic                   frame_acc_q, frame_acc_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;

  logic rx_s;
  logic par_calc;

  assign rx_s     = sync2_q;
  assign par_calc = (^shift_q) ^ 1'(PARITY_ODD);

  always_comb begin
    // NOTE: every _d gets a default here first, so no path through the case can infer a latch.
    state_d      = state_q;
    sync1_d      = data_in;
    sync2_d      = sync1_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_acc_d    = par_acc_q;
    frame_acc_d  = frame_acc_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (rx_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d     = ST_START;
            tick_cnt_d  = '0;
            par_acc_d   = 1'b0;
            frame_acc_d = 1'b0;
          end
        end
        ST_START: begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else if (tick_cnt_q == TICK_MID) begin
            state_d    = ST_DATA;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        ST_DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            // Shifting in at the MSB leaves the first-received bit in the LSB after DATA_BITS shifts.
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BIT_LAST) begin
              state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
              bit_cnt_d = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        ST_PARITY: begin
          if (tick_cnt_q == TICK_LAST) begin
            par_acc_d  = (rx_s != par_calc);
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = ST_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        ST_STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d  = '0;
            frame_acc_d = frame_acc_q | ~rx_s;
            if (bit_cnt_q == STOP_LAST) begin
              // Return to IDLE at mid-stop so a start edge half a bit later is still caught.
              state_d      = ST_IDLE;
              data_out_d   = shift_q;
              parity_err_d = par_acc_q;
              frame_err_d  = frame_acc_q | ~rx_s;
              data_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates are non-blocking so every flop samples pre-edge values, free of ordering races.
    if (rst) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      frame_acc_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_acc_q    <= par_acc_d;
      frame_acc_q  <= frame_acc_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances cover plain 8N1, even parity and two stop bits.
// The transmitter counts rx_en ticks, so gating rx_en stalls the line and the receiver together.
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_en = 1'b0;
  logic gate = 1'b1;
  logic line [0:2];

  logic [7:0] b_data, p_data, s_data;
  logic       b_valid, p_valid, s_valid;
  logic       b_perr, p_perr, s_perr;
  logic       b_ferr, p_ferr, s_ferr;
  logic       b_busy, p_busy, s_busy;

  int n_vec = 0;
  int n_bad = 0;
  int b_vcnt = 0;
  int p_vcnt = 0;
  int s_vcnt = 0;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_base (
    .clk(clk), .rst(rst), .rx_en(rx_en), .data_in(line[0]),
    .data_out(b_data), .data_valid(b_valid), .parity_err(b_perr), .frame_err(b_ferr), .busy(b_busy)
  );

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_par (
    .clk(clk), .rst(rst), .rx_en(rx_en), .data_in(line[1]),
    .data_out(p_data), .data_valid(p_valid), .parity_err(p_perr), .frame_err(p_ferr), .busy(p_busy)
  );

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .rx_en(rx_en), .data_in(line[2]),
    .data_out(s_data), .data_valid(s_valid), .parity_err(s_perr), .frame_err(s_ferr), .busy(s_busy)
  );

  always #5 clk = ~clk;

  // rx_en: one clk wide every 4 clk, updated on negedge so it is stable at the sampling edge.
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      rx_en = gate && (div == 0);
    end
  end

  // Counting high negedge samples also catches a strobe wider than one clk.
  always @(negedge clk) if (b_valid) b_vcnt++;
  always @(negedge clk) if (p_valid) p_vcnt++;
  always @(negedge clk) if (s_valid) s_vcnt++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (rx_en) c++;
    end
    #1;
  endtask

  // Sends n bits of v LSB first, 16 ticks each except the last, which lasts last_ticks.
  task automatic send(input int idx, input logic [15:0] v, input int n, input int last_ticks);
    for (int i = 0; i < n; i++) begin
      line[idx] = v[i];
      wait_ticks((i == n - 1) ? last_ticks : 16);
    end
    line[idx] = 1'b1;
  endtask

  function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop);
    return {7'd0, stop, d, 1'b0};
  endfunction

  initial begin
    int v0;
    line[0] = 1'b1;
    line[1] = 1'b1;
    line[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    check("rst_data", 16'(b_data), 16'h00);
    check("rst_valid", 16'(b_valid), 16'h0);
    check("rst_perr", 16'(b_perr), 16'h0);
    check("rst_ferr", 16'(b_ferr), 16'h0);
    check("rst_busy", 16'(b_busy), 16'h0);
    wait_ticks(8);

    // Plain 8N1 frame.
    v0 = b_vcnt;
    send(0, frame8(8'hA5, 1'b1), 10, 16);
    check("a5_pulses", 16'(b_vcnt - v0), 16'd1);
    check("a5_data", 16'(b_data), 16'hA5);
    check("a5_perr", 16'(b_perr), 16'h0);
    check("a5_ferr", 16'(b_ferr), 16'h0);
    check("a5_busy", 16'(b_busy), 16'h0);

    // Glitch shorter than half a bit.
    v0 = b_vcnt;
    line[0] = 1'b0;
    wait_ticks(2);
    check("glitch_busy_hi", 16'(b_busy), 16'h1);
    wait_ticks(3);
    line[0] = 1'b1;
    wait_ticks(20);
    check("glitch_busy_lo", 16'(b_busy), 16'h0);
    check("glitch_pulses", 16'(b_vcnt - v0), 16'd0);
    check("glitch_data", 16'(b_data), 16'hA5);

    // Even parity: 0x37 has five ones, so the correct parity bit is 1.
    v0 = p_vcnt;
    send(1, {5'd0, 1'b1, 1'b1, 8'h37, 1'b0}, 11, 16);
    check("par_ok_pulses", 16'(p_vcnt - v0), 16'd1);
    check("par_ok_data", 16'(p_data), 16'h37);
    check("par_ok_perr", 16'(p_perr), 16'h0);
    v0 = p_vcnt;
    send(1, {5'd0, 1'b1, 1'b0, 8'h37, 1'b0}, 11, 16);
    check("par_bad_pulses", 16'(p_vcnt - v0), 16'd1);
    check("par_bad_data", 16'(p_data), 16'h37);
    check("par_bad_perr", 16'(p_perr), 16'h1);
    check("par_bad_ferr", 16'(p_ferr), 16'h0);

    // Stop bit low: framing error; line released before a new start could be accepted.
    v0 = b_vcnt;
    send(0, frame8(8'h3C, 1'b0), 10, 10);
    wait_ticks(16);
    check("fe_pulses", 16'(b_vcnt - v0), 16'd1);
    check("fe_data", 16'(b_data), 16'h3C);
    check("fe_ferr", 16'(b_ferr), 16'h1);
    check("fe_busy", 16'(b_busy), 16'h0);

    // Two stop bits: clean frame, then only the second stop bit low.
    v0 = s_vcnt;
    send(2, {5'd0, 2'b11, 8'hC3, 1'b0}, 11, 16);
    check("s2_ok_data", 16'(s_data), 16'hC3);
    check("s2_ok_ferr", 16'(s_ferr), 16'h0);
    send(2, {5'd0, 2'b01, 8'h3C, 1'b0}, 11, 10);
    wait_ticks(16);
    check("s2_bad_pulses", 16'(s_vcnt - v0), 16'd2);
    check("s2_bad_data", 16'(s_data), 16'h3C);
    check("s2_bad_ferr", 16'(s_ferr), 16'h1);
    check("s2_perr", 16'(s_perr), 16'h0);

    // Back-to-back frames with no idle gap.
    v0 = b_vcnt;
    send(0, frame8(8'h55, 1'b1), 10, 16);
    check("b2b_first", 16'(b_data), 16'h55);
    check("b2b_first_ferr", 16'(b_ferr), 16'h0);
    send(0, frame8(8'hAA, 1'b1), 10, 16);
    check("b2b_second", 16'(b_data), 16'hAA);
    check("b2b_pulses", 16'(b_vcnt - v0), 16'd2);
    check("b2b_ferr", 16'(b_ferr), 16'h0);

    // Reset during bit 4 of 0xFF, then a clean 0x12.
    v0 = b_vcnt;
    line[0] = 1'b0;
    wait_ticks(16);
    line[0] = 1'b1;
    wait_ticks(4 * 16 + 8);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", 16'(b_busy), 16'h0);
    check("abort_data", 16'(b_data), 16'h00);
    wait_ticks(48);
    check("abort_pulses", 16'(b_vcnt - v0), 16'd0);
    send(0, frame8(8'h12, 1'b1), 10, 16);
    check("post_rst_data", 16'(b_data), 16'h12);
    check("post_rst_pulses", 16'(b_vcnt - v0), 16'd1);

    // rx_en held low for 50 clk in mid-frame.
    v0 = b_vcnt;
    fork
      send(0, frame8(8'h6B, 1'b1), 10, 16);
      begin
        wait_ticks(40);
        gate = 1'b0;
        repeat (50) @(posedge clk);
        #1 gate = 1'b1;
      end
    join
    check("stall_data", 16'(b_data), 16'h6B);
    check("stall_pulses", 16'(b_vcnt - v0), 16'd1);
    check("stall_ferr", 16'(b_ferr), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receive engine for the communication subsystem. It succeeds the fixed 8-bit, 16x-oversampled receiver with configurable data width, oversampling factor, optional parity and 1 or 2 stop bits. It adds an input synchroniser, false-start rejection, a single-cycle valid strobe, and parity and framing error flags. Baud timing comes from an external oversample tick generator driving rx_en.

Parameters:
DATA_BITS, 8, payload bits per frame; legal 5..9; sent LSB first
OVERSAMPLE, 16, rx_en ticks per bit period; even, >=4
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits checked; 1 or 2

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
rx_en  in  1  oversample tick, 1 clk wide, OVERSAMPLE per bit period
data_in  in  1  asynchronous serial line, idle high
data_out  out  DATA_BITS  last received word; held until the next frame completes
data_valid  out  1  1-clk pulse when data_out/errors update
parity_err  out  1  parity mismatch for the frame flagged by data_valid
frame_err  out  1  a stop-bit sample was 0 for the frame flagged by data_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE, counters=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, synchroniser flops=1. Reset mid-frame discards the partial word with no valid pulse.
- data_in passes through a 2-flop synchroniser to give rx_s. This adds 2 clk of latency. All decisions use rx_s.
- All state and counter advances happen only on clk edges with rx_en=1, except the data_valid clear. While rx_en=0 everything holds.
- tick_cnt width is $clog2(OVERSAMPLE). bit_cnt width is $clog2(DATA_BITS+1).
- IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
- START:
  - On each tick, tick_cnt increments.
  - If rx_s=1 on any tick before the mid point, this is a false start: go to IDLE with no flags.
  - On the tick where tick_cnt==OVERSAMPLE/2-1 and rx_s=0, go to DATA with tick_cnt=0 and bit_cnt=0. The mid-start point is thereby aligned.
- DATA:
  - On the tick where tick_cnt==OVERSAMPLE-1, shift rx_s into bit position bit_cnt of the shift register (LSB first), clear tick_cnt and increment bit_cnt.
  - After bit DATA_BITS-1, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: sample at tick_cnt==OVERSAMPLE-1. The computed parity is XOR(data) XOR PARITY_ODD. Store the mismatch flag, then go to STOP.
- STOP:
  - Sample at tick_cnt==OVERSAMPLE-1 for each of STOP_BITS bits and OR any 0 into the frame flag.
  - On the final stop sample:
    - Load data_out from the shift register and load the error registers.
    - Set data_valid=1 for exactly one clk.
    - Return to IDLE on the same edge. No wait for the stop-bit end, so a start edge half a bit later is caught.
- A frame with a framing error still loads data_out and pulses data_valid, with frame_err=1. A break (all-zero line) therefore reports data 0 with frame_err=1, then IDLE waits for rx_s=0 again. While the line stays low this re-enters START, so a continuous break repeats error frames.
- parity_err is always 0 when PARITY_EN=0. Error outputs hold their values until the next data_valid.
- Sample latency: data_valid is asserted on the clk after the edge that takes the last stop sample. This is about (1+DATA_BITS+PARITY_EN+STOP_BITS-0.5) bit periods + 2 clk after the falling edge of data_in.

Test Plan:
- DATA_BITS=8, OVERSAMPLE=16, rx_en every 4 clk, no parity: send 0xA5 with 1 stop bit -> one data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, busy low afterwards.
- Glitch: hold data_in low for 5 ticks (< 8), then high -> busy pulses, then IDLE; no data_valid, data_out unchanged.
- PARITY_EN=1, PARITY_ODD=0: send 0x37 with parity bit 1 -> parity_err=0. Same frame with parity bit 0 -> data_out=0x37, parity_err=1.
- Send 0x3C with the stop bit driven 0 -> data_valid pulses, data_out=0x3C, frame_err=1. With STOP_BITS=2, a 0 only in the 2nd stop bit -> frame_err=1.
- Back-to-back: 0x55 then 0xAA with a start edge immediately after 1 stop bit -> two valid pulses, values in order, no errors.
- Assert rst during bit 4 of 0xFF, then send 0x12 -> no pulse for the aborted frame; 0x12 is received correctly. Gate rx_en low for 50 clk mid-frame -> result unchanged.
